// File: rtl/shared_gate_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit (NOT/AND/OR/XOR) among N_REQ requesters.
// Optional per-requester saturating grant counters are enabled by defining SHARED_GATE_STATS_EN.
module shared_gate_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [2*N_REQ-1:0]         req_op,
  input  logic [WIDTH*N_REQ-1:0]     req_a,
  input  logic [WIDTH*N_REQ-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_data
`ifdef SHARED_GATE_STATS_EN
  ,
  output logic [16*N_REQ-1:0]        grant_count
`endif
);
  localparam int ID_W = $clog2(N_REQ);

  function automatic logic [WIDTH-1:0] f_gate(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    f_gate = ~a;
      2'd1:    f_gate = a & b;
      2'd2:    f_gate = a | b;
      default: f_gate = a ^ b;
    endcase
  endfunction

  logic [ID_W-1:0]  r_ptr;
  logic             r_vld_p1;
  logic [ID_W-1:0]  r_id_p1;
  logic [WIDTH-1:0] r_data_p1;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_idx;
  logic             w_slot_avail;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [N_REQ-1:0] w_req_ready;

  // Stage 0: rotating-priority search starting at r_ptr, operand select
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_slot_avail = ~r_vld_p1 | rsp_ready;
  assign w_accept     = w_found & w_slot_avail & ~rst;
  assign w_op         = req_op[2*int'(w_win) +: 2];
  assign w_a          = req_a[WIDTH*int'(w_win) +: WIDTH];
  assign w_b          = req_b[WIDTH*int'(w_win) +: WIDTH];

  always_comb begin
    w_req_ready = '0;
    if (w_accept) w_req_ready[w_win] = 1'b1;
  end

  assign req_ready = w_req_ready;

  // Stage 1: single-entry result slot; drain and refill may happen in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_vld_p1  <= 1'b0;
      r_id_p1   <= '0;
      r_data_p1 <= '0;
    end else if (w_accept) begin
      r_vld_p1  <= 1'b1;
      r_id_p1   <= w_win;
      r_data_p1 <= f_gate(w_op, w_a, w_b);
      r_ptr     <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end else if (r_vld_p1 && rsp_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign rsp_valid = r_vld_p1;
  assign rsp_id    = r_id_p1;
  assign rsp_data  = r_data_p1;

`ifdef SHARED_GATE_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stats
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_req_ready[g] && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign grant_count[16*g +: 16] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_shared_gate_arbiter.sv
// Directed self-checking bench for shared_gate_arbiter (N_REQ=4, WIDTH=8).
// Covers the stats counters too when SHARED_GATE_STATS_EN is defined.
module tb_shared_gate_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
`ifdef SHARED_GATE_STATS_EN
  logic [63:0] grant_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shared_gate_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef SHARED_GATE_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  // Drive on the falling edge, settle, then sample combinational outputs.
  task automatic drive_edge();
    @(negedge clk);
  endtask

  task automatic after_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    rst = 1'b1;
    after_clk();
    drive_edge();
    rst = 1'b0;
  endtask

  logic [1:0] exp_id;
  logic [7:0] exp_data [4];

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    // Table for the rotation test: 0:AND 1:OR 2:XOR 3:NOT
    exp_data[0] = 8'h01;
    exp_data[1] = 8'h2F;
    exp_data[2] = 8'h4B;
    exp_data[3] = 8'h77;

    repeat (2) after_clk();
    drive_edge();
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_id",    64'(rsp_id),    64'd0);
    check("reset_rsp_data",  64'(rsp_data),  64'h00);
    check("reset_req_ready", 64'(req_ready), 64'h0);

    // Single AND request from requester 1
    rst       = 1'b0;
    req_valid = 4'b0010;
    set_req(1, 2'd1, 8'hF0, 8'h3C);
    #1;
    check("single_req_ready", 64'(req_ready), 64'b0010);
    after_clk();
    check("single_rsp_valid", 64'(rsp_valid), 64'd1);
    check("single_rsp_id",    64'(rsp_id),    64'd1);
    check("single_rsp_data",  64'(rsp_data),  64'h30);
    check("single_full_no_ready", 64'(req_ready), 64'h0);
    drive_edge();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    after_clk();
    check("drain_rsp_valid", 64'(rsp_valid), 64'd0);

    // NOT from requester 0, b must be ignored
    drive_edge();
    req_valid = 4'b0001;
    set_req(0, 2'd0, 8'hA5, 8'hFF);
    #1;
    check("not_req_ready", 64'(req_ready), 64'b0001);
    after_clk();
    check("not_rsp_id",   64'(rsp_id),   64'd0);
    check("not_rsp_data", 64'(rsp_data), 64'h5A);
    drive_edge();
    req_valid = 4'b0000;
    after_clk();

    // Rotation with all requesters valid and consumer always ready
    do_reset();
    set_req(0, 2'd1, 8'h11, 8'h0F);
    set_req(1, 2'd2, 8'h22, 8'h0F);
    set_req(2, 2'd3, 8'h44, 8'h0F);
    set_req(3, 2'd0, 8'h88, 8'h0F);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_id = 2'(c % 4);
      #1;
      check($sformatf("rot%0d_req_ready", c), 64'(req_ready), 64'(4'b0001 << exp_id));
      after_clk();
      check($sformatf("rot%0d_rsp_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("rot%0d_rsp_id", c),    64'(rsp_id),    64'(exp_id));
      check($sformatf("rot%0d_rsp_data", c),  64'(rsp_data),  64'(exp_data[exp_id]));
      drive_edge();
    end

    // Backpressure: slot holds requester 3's NOT result
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_req_ready", c), 64'(req_ready), 64'h0);
      after_clk();
      check($sformatf("bp%0d_rsp_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d_rsp_id", c),    64'(rsp_id),    64'd3);
      check($sformatf("bp%0d_rsp_data", c),  64'(rsp_data),  64'h77);
      drive_edge();
    end
    rsp_ready = 1'b1;
    #1;
    check("refill_req_ready", 64'(req_ready), 64'b0001);
    after_clk();
    check("refill_rsp_valid", 64'(rsp_valid), 64'd1);
    check("refill_rsp_id",    64'(rsp_id),    64'd0);
    check("refill_rsp_data",  64'(rsp_data),  64'h01);

    // Reset while FULL and stalled; ptr was 1 beforehand
    drive_edge();
    rsp_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'h0);
    after_clk();
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    drive_edge();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    #1;
    check("midrst_ptr_zero", 64'(req_ready), 64'b0001);
    after_clk();
    check("midrst_first_id", 64'(rsp_id), 64'd0);
    drive_edge();
    req_valid = 4'b0100;
    #1;
    check("req2_req_ready", 64'(req_ready), 64'b0100);
    after_clk();
    check("req2_rsp_id",   64'(rsp_id),   64'd2);
    check("req2_rsp_data", 64'(rsp_data), 64'h4B);
    drive_edge();
    req_valid = 4'b0000;

`ifdef SHARED_GATE_STATS_EN
    do_reset();
    #1;
    check("stats_cleared", grant_count, 64'h0);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    repeat (5) after_clk();
    drive_edge();
    req_valid = 4'b0000;
    #1;
    check("stats_req3_five", grant_count, {16'd5, 48'd0});
`endif

    after_clk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
